// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared states, funct3 encodings and constants for the RV32M multiply/divide unit
package muldiv_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int FUNCT3_WIDTH = 3;
  localparam int ITER = DATA_WIDTH;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage request/flush inputs and stall/result outputs of the M-extension unit
interface muldiv_if import muldiv_pkg::*;;
  logic CLR;
  logic MulDivE;
  logic [FUNCT3_WIDTH-1:0] funct3E;
  logic [DATA_WIDTH-1:0] SrcAE;
  logic [DATA_WIDTH-1:0] SrcBE;
  logic MulDivBusyE;
  logic MulDivDoneE;
  logic [DATA_WIDTH-1:0] MulDivResultE;
  modport master(output CLR, MulDivE, funct3E, SrcAE, SrcBE,
                 input MulDivBusyE, MulDivDoneE, MulDivResultE);
  modport slave(input CLR, MulDivE, funct3E, SrcAE, SrcBE,
                output MulDivBusyE, MulDivDoneE, MulDivResultE);
endinterface

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one shift-add (mode 0) or restoring-subtract (mode 1) step on a 64-bit accumulator
module muldiv_iter_core import muldiv_pkg::*; (
  input  logic                  mode_i,
  input  logic [63:0]           acc_i,
  input  logic [DATA_WIDTH-1:0] opd_i,
  output logic [63:0]           acc_o
);
  logic [32:0] sum, diff;
  // divide keeps {remainder, quotient}; the remainder shifted left is acc_i[63:31]
  always_comb begin
    sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opd_i} : 33'd0);
    diff = acc_i[63:31] - {1'b0, opd_i};
    acc_o = !mode_i ? {sum, acc_i[31:1]} : diff[32] ? {acc_i[62:0], 1'b0} : {diff[31:0], acc_i[30:0], 1'b1};
  end
endmodule

// File: rtl/muldiv_e.sv
// muldiv_e: iterative RV32M multiply/divide with pipeline stall and one-cycle done pulse
// MULDIV_FAST_MUL_EN selects a single-cycle combinational multiply; divides stay iterative.
module muldiv_e import muldiv_pkg::*; (
  input logic     CLK,
  input logic     RST_N,
  muldiv_if.slave bus
);
  state_t state_q, state_d;
  logic [63:0] acc_q, acc_d, acc_n, p;
  logic [31:0] opd_q, opd_d, res_q, res_d, fin, q, r, ma, mb, spv;
  logic [4:0] cnt_q, cnt_d;
  logic [2:0] f3_q, f3_d, f3;
  logic neg_q, neg_d, rneg_q, rneg_d, spec_q, spec_d;
  logic start, sa, sb, div0, ovf;
  assign f3 = bus.funct3E;
  assign start = bus.MulDivE & ~bus.CLR;
  assign sa = bus.SrcAE[31] & ~(f3 == F3_MULHU || f3 == F3_DIVU || f3 == F3_REMU);
  assign sb = bus.SrcBE[31] & (f3 == F3_MUL || f3 == F3_MULH || f3 == F3_DIV || f3 == F3_REM);
  assign ma = sa ? -bus.SrcAE : bus.SrcAE;
  assign mb = sb ? -bus.SrcBE : bus.SrcBE;
  assign div0 = bus.SrcBE == '0;
  assign ovf = ~f3[0] & (bus.SrcAE == INT_MIN) & (bus.SrcBE == ALL_ONES);
  assign spv = div0 ? (f3[1] ? bus.SrcAE : ALL_ONES) : (f3[1] ? 32'd0 : INT_MIN);
  muldiv_iter_core u_core (
    .mode_i(state_q == DIV),
    .acc_i (acc_q),
    .opd_i (opd_q),
    .acc_o (acc_n)
  );
  assign p = neg_q ? -acc_q : acc_q;
  assign q = neg_q ? -acc_q[31:0] : acc_q[31:0];
  assign r = rneg_q ? -acc_q[63:32] : acc_q[63:32];
  assign fin = spec_q ? acc_q[31:0] : !f3_q[2] ? (f3_q == F3_MUL ? p[31:0] : p[63:32]) : f3_q[1] ? r : q;
  assign bus.MulDivBusyE = RST_N & ((state_q == IDLE && start) || state_q == MUL || state_q == DIV);
  assign bus.MulDivDoneE = (state_q == DONE) & ~bus.CLR;
  assign bus.MulDivResultE = bus.MulDivDoneE ? fin : res_q;
  always_comb begin
    state_d = state_q;
    acc_d = acc_q;
    opd_d = opd_q;
    res_d = res_q;
    cnt_d = cnt_q;
    f3_d = f3_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    spec_d = spec_q;
    case (state_q)
      IDLE: if (start) begin
        f3_d = f3;
        neg_d = sa ^ sb;
        rneg_d = sa;
        spec_d = 1'b0;
        cnt_d = '0;
        opd_d = f3[2] ? mb : ma;
        acc_d = {32'd0, f3[2] ? ma : mb};
        if (f3[2] && (div0 || ovf)) begin
          state_d = DONE;
          spec_d = 1'b1;
          acc_d = {32'd0, spv};
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!f3[2]) begin
          state_d = DONE;
          acc_d = {32'd0, ma} * {32'd0, mb};
        end
`endif
        else state_d = f3[2] ? DIV : MUL;
      end
      MUL, DIV: begin
        acc_d = acc_n;
        cnt_d = cnt_q + 5'd1;
        state_d = (cnt_q == 5'(ITER - 1)) ? DONE : state_q;
      end
      default: begin
        res_d = fin;
        state_d = IDLE;
      end
    endcase
    if (bus.CLR) begin
      state_d = IDLE;
      res_d = res_q;
    end
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= IDLE;
      acc_q <= '0;
      opd_q <= '0;
      res_q <= '0;
      cnt_q <= '0;
      f3_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      spec_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      opd_q <= opd_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      f3_q <= f3_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      spec_q <= spec_d;
    end
endmodule

// File: tb/tb_muldiv_e.sv
// tb_muldiv_e: directed vectors for muldiv_e with hand-computed results and latencies
module tb_muldiv_e;
  import muldiv_pkg::*;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int total = 0;
  int passed = 0;
  int lat, nbusy, ndone;
  logic [31:0] res;
  muldiv_if bus();
  muldiv_e dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else passed++;
  endtask
  task automatic drive(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.MulDivE = 1'b1;
    bus.funct3E = f;
    bus.SrcAE = a;
    bus.SrcBE = b;
  endtask
  // called just after a negedge where the op is presented: that negedge is cycle 0
  task automatic wait_done(output int l, output int nb, output logic [31:0] rs);
    l = -1;
    nb = 0;
    rs = '0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (bus.MulDivBusyE) nb++;
      if (bus.MulDivDoneE) begin
        l = c;
        rs = bus.MulDivResultE;
        break;
      end
      @(negedge CLK);
    end
  endtask
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int l, output int nb, output logic [31:0] rs);
    @(negedge CLK);
    drive(f, a, b);
    wait_done(l, nb, rs);
    bus.MulDivE = 1'b0;
  endtask
  initial begin
    bus.CLR = 1'b0;
    bus.MulDivE = 1'b0;
    bus.funct3E = '0;
    bus.SrcAE = '0;
    bus.SrcBE = '0;
    #12;
    check("rst_busy", {31'd0, bus.MulDivBusyE}, 32'd0);
    check("rst_done", {31'd0, bus.MulDivDoneE}, 32'd0);
    check("rst_result", bus.MulDivResultE, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    run_op(F3_MUL, 32'd7, 32'hFFFF_FFFD, lat, nbusy, res);
    check("mul_res", res, 32'hFFFF_FFEB);
    check("mul_lat", 32'(lat), 32'd33);
    check("mul_busy_cycles", 32'(nbusy), 32'd33);
    run_op(F3_MULH, 32'h8000_0000, 32'h8000_0000, lat, nbusy, res);
    check("mulh_res", res, 32'h4000_0000);
    check("mulh_lat", 32'(lat), 32'd33);
    run_op(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nbusy, res);
    check("mulhu_res", res, 32'hFFFF_FFFE);
    run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, nbusy, res);
    check("mulhsu_res", res, 32'hFFFF_FFFF);
    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, lat, nbusy, res);
    check("div_res", res, 32'hFFFF_FFFD);
    check("div_lat", 32'(lat), 32'd33);
    run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, lat, nbusy, res);
    check("rem_res", res, 32'hFFFF_FFFF);
    run_op(F3_REMU, 32'd100, 32'd7, lat, nbusy, res);
    check("remu_res", res, 32'd2);
    check("remu_lat", 32'(lat), 32'd33);
    run_op(F3_DIVU, 32'd100, 32'd7, lat, nbusy, res);
    check("divu_res", res, 32'd14);
    check("divu_lat", 32'(lat), 32'd33);
    // abort a multiply at iteration cycle 10; result must keep the 14 from DIVU
    @(negedge CLK);
    drive(F3_MUL, 32'd7, 32'hFFFF_FFFD);
    for (int c = 0; c < 10; c++) @(negedge CLK);
    bus.CLR = 1'b1;
    #1;
    check("clr_cycle_done", {31'd0, bus.MulDivDoneE}, 32'd0);
    @(negedge CLK);
    bus.CLR = 1'b0;
    bus.MulDivE = 1'b0;
    #1;
    check("clr_busy", {31'd0, bus.MulDivBusyE}, 32'd0);
    check("clr_result_kept", bus.MulDivResultE, 32'd14);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      #1;
      if (bus.MulDivDoneE) ndone++;
    end
    check("clr_no_done", 32'(ndone), 32'd0);
    run_op(F3_DIV, 32'd5, 32'd0, lat, nbusy, res);
    check("div0_res", res, 32'hFFFF_FFFF);
    check("div0_lat", 32'(lat), 32'd1);
    check("div0_busy_cycles", 32'(nbusy), 32'd1);
    run_op(F3_REMU, 32'd5, 32'd0, lat, nbusy, res);
    check("remu0_res", res, 32'd5);
    check("remu0_lat", 32'(lat), 32'd1);
    run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, nbusy, res);
    check("divovf_res", res, 32'h8000_0000);
    check("divovf_lat", 32'(lat), 32'd1);
    run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, nbusy, res);
    check("removf_res", res, 32'd0);
    // back-to-back: MulDivE stays high through DONE, next MUL starts in the following IDLE
    @(negedge CLK);
    drive(F3_MUL, 32'd3, 32'd5);
    wait_done(lat, nbusy, res);
    check("b2b_first_res", res, 32'd15);
    check("b2b_done_busy", {31'd0, bus.MulDivBusyE}, 32'd0);
    drive(F3_MUL, 32'd6, 32'd7);
    @(negedge CLK);
    wait_done(lat, nbusy, res);
    bus.MulDivE = 1'b0;
    check("b2b_second_res", res, 32'd42);
    check("b2b_second_lat", 32'(lat), 32'd33);
    // asynchronous reset in the middle of a divide
    @(negedge CLK);
    drive(F3_DIVU, 32'd100, 32'd7);
    for (int c = 0; c < 5; c++) @(negedge CLK);
    #1;
    check("pre_rst_busy", {31'd0, bus.MulDivBusyE}, 32'd1);
    RST_N = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, bus.MulDivBusyE}, 32'd0);
    check("async_rst_done", {31'd0, bus.MulDivDoneE}, 32'd0);
    check("async_rst_result", bus.MulDivResultE, 32'd0);
    bus.MulDivE = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    run_op(F3_MUL, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat, nbusy, res);
    check("post_rst_mul_res", res, 32'd6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
